uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Round-robin scheduler that shares one UART transmitter among NUM_REQ requesters.
//  Picks a pending requester and latches its byte onto data_frame.
//  Fires a one-cycle frame_en, then waits for the transmitter's tx_done and acks the winner.
//  Sits between the protocol clients and the UART transmitter.
//  Adds an inter-frame guard gap and a watchdog so a hung transmitter cannot lock the bus.
// PARAMETERS
//  NUM_REQ      4        number of requesters, 2..16
//  FRAME_WD     8        data bits per frame; must equal the transmitter's FRAME_WD
//  GAP_CYC      16       idle clk cycles between frames; 0 = no gap
//  TIMEOUT_CYC  65536    clk cycles from frame_en to abort if no tx_done; >= 1 frame time
// PORTS
//  clk          in   1                 system clock
//  rst_n        in   1                 asynchronous active-low reset
//  req          in   NUM_REQ           req[i]=1: requester i has a byte pending
//  req_data     in   NUM_REQ*FRAME_WD  byte of requester i at [i*FRAME_WD +: FRAME_WD]
//  req_ack      out  NUM_REQ           one-hot 1-cycle pulse: requester i's byte sent
//  frame_en     out  1                 1-cycle start pulse to the transmitter
//  data_frame   out  FRAME_WD          byte to the transmitter; held stable for the whole frame
//  tx_done      in   1                 transmitter frame-complete pulse
//  busy         out  1                 1 in any state other than IDLE
//  grant_id     out  $clog2(NUM_REQ)   index of the current/last granted requester
//  timeout_err  out  1                 1-cycle pulse when the watchdog aborts a frame
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; req_ack=0, frame_en=0, data_frame=0, busy=0, grant_id=0, timeout_err=0.
//   - RR pointer=0, so requester 0 has highest priority.
//   - Reset mid-frame drops the frame silently: no ack, no error.
//  FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
//   IDLE:
//    - If |req, grant the first set bit searching from ptr upward, wrapping at NUM_REQ.
//    - Latch grant_id and data_frame = that requester's slice, then go to LAUNCH.
//    - tx_done seen in IDLE or GAP is ignored.
//   LAUNCH:
//    - frame_en=1 for exactly this cycle; clear the watchdog counter; go to WAIT_DONE.
//   WAIT_DONE:
//    - On tx_done: req_ack[grant_id]=1 next cycle; ptr = grant_id+1 (mod NUM_REQ); go to GAP.
//    - Else, when the counter reaches TIMEOUT_CYC-1: timeout_err=1 for one cycle, no ack.
//      ptr still advances; go to GAP.
//    - tx_done in the same cycle as the timeout: tx_done wins (ack, no error).
//   GAP:
//    - Count GAP_CYC cycles, then go to IDLE.
//    - GAP_CYC=0: move straight to IDLE the next cycle.
//  Timing:
//   - Grant latency is 1 cycle from req to LAUNCH; frame_en is registered.
//   - With GAP_CYC=0, back-to-back frames are frame_en pulses 3 cycles + frame time apart.
//  Hold rules:
//   - data_frame and grant_id hold from IDLE exit until the next grant.
//     The transmitter samples data late, at its start bit.
//   - A requester keeps req and its data stable until its ack.
//     Dropping req mid-frame does not abort the frame, and the ack still pulses.
//   - A requester that keeps req high after its ack is treated as a new byte.
//     It is re-granted only after all other pending requesters: fairness bound NUM_REQ frames.
//  Watchdog counter: $clog2(TIMEOUT_CYC+1) bits, saturating; cleared in LAUNCH.
// TESTING
//  1 Single req: req=4'b0100, data2=8'hA5 -> frame_en pulse; data_frame=A5, grant_id=2;
//    after tx_done, req_ack=4'b0100.
//  2 All pending: req=4'hF after reset -> grant order 0,1,2,3,0.
//    Each ack arrives only after its tx_done; frame_en pulses never overlap.
//  3 Hold check: with a real transmitter model at 9600 baud,
//    change req_data during the frame -> serialized byte equals the latched byte.
//  4 Timeout: TIMEOUT_CYC=100, tx_done never asserted -> timeout_err pulses 100 cycles
//    after frame_en; no ack; the next requester is granted after GAP.
//  5 Stray/race: tx_done pulsed in IDLE -> no ack.
//    tx_done on the timeout cycle -> ack=1, timeout_err=0.
//  6 Reset mid-frame: rst_n low in WAIT_DONE -> all outputs 0, ptr=0;
//    after release, requester 0 wins over 3 when req=4'b1001.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ requesters.
// It adds an inter-frame guard gap and a watchdog that aborts a frame when the transmitter hangs.
module uart_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_WD    = 8,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FRAME_WD-1:0]   req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          frame_en,
  output logic [FRAME_WD-1:0]           data_frame,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          timeout_err
);

  localparam int ID_W     = $clog2(NUM_REQ);
  localparam int WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W    = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [FRAME_WD-1:0] data_q, data_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                fen_q, fen_d;
  logic                terr_q, terr_d;

  logic                pick_valid;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     ptr_next;

  // Scan offsets from the highest down so the lowest offset from ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % NUM_REQ]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign ptr_next = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    data_d     = data_q;
    wd_d       = wd_q;
    gap_d      = gap_q;
    ack_d      = '0;
    fen_d      = 1'b0;
    terr_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_id;
          data_d     = req_data[pick_id*FRAME_WD +: FRAME_WD];
          fen_d      = 1'b1;
          wd_d       = '0;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_d    = wd_q + 1'b1;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // tx_done has priority over a watchdog expiry in the same cycle.
        if (tx_done) begin
          ack_d[grant_id_q] = 1'b1;
          ptr_d             = ptr_next;
          gap_d             = '0;
          state_d           = S_GAP;
        end else if (wd_q >= WD_W'(TIMEOUT_CYC - 1)) begin
          terr_d  = 1'b1;
          ptr_d   = ptr_next;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q >= GAP_W'(GAP_LAST)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      data_q     <= '0;
      wd_q       <= '0;
      gap_q      <= '0;
      ack_q      <= '0;
      fen_q      <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      data_q     <= data_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
      ack_q      <= ack_d;
      fen_q      <= fen_d;
      terr_q     <= terr_d;
    end
  end

  assign req_ack     = ack_q;
  assign frame_en    = fen_q;
  assign data_frame  = data_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = terr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a round-robin reference model plus a
// simple transmitter stand-in that samples data late and answers with tx_done.
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int GAP  = 3;
  localparam int TMO  = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        frame_en;
  logic [7:0]  data_frame;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int m_ptr    = 0;

  uart_tx_sched #(
    .NUM_REQ(NREQ), .FRAME_WD(8), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_ack(req_ack),
    .frame_en(frame_en), .data_frame(data_frame), .tx_done(tx_done), .busy(busy),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference arbitration: first pending requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
  endtask

  // Waits for frame_en, plays the transmitter for len cycles, pulses tx_done and
  // returns what was observed (no judging here; the tests compare).
  task automatic run_frame(input int len, input bit scramble, output bit ok,
                           output int waited, output int gid, output logic [7:0] dat,
                           output logic [7:0] late, output logic [3:0] ack,
                           output bit stray, output logic terr);
    ok = 1'b0; waited = 0; gid = -1; dat = 'x; late = 'x; ack = 'x; stray = 1'b0; terr = 1'bx;
    while (!frame_en && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!frame_en) return;
    ok  = 1'b1;
    gid = int'(grant_id);
    dat = data_frame;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (frame_en || req_ack != 4'b0 || timeout_err) stray = 1'b1;
      if (scramble) req_data = $urandom;
      if (i == (len + 1) / 2) late = data_frame;
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    ack  = req_ack;
    terr = timeout_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_data = '0; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_ack, frame_en, data_frame, busy, grant_id, timeout_err} !== 17'b0)
      $display("FAIL reset_outputs: got ack=%b fen=%b data=%h busy=%b gid=%0d terr=%b, want all 0",
               req_ack, frame_en, data_frame, busy, grant_id, timeout_err);
    else n_pass++;
    rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_all_pending();
    bit ok, stray; int waited, gid; logic [7:0] dat, late; logic [3:0] ack; logic terr;
    int order[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
    req = 4'hF;
    for (int f = 0; f < 5; f++) begin
      run_frame(5 + f, 1'b0, ok, waited, gid, dat, late, ack, stray, terr);
      n_checks++;
      if (!ok || gid != order[f] || gid != rr_pick(req, m_ptr))
        $display("FAIL all_pending_grant%0d: got %0d, want %0d", f, gid, order[f]);
      else n_pass++;
      n_checks++;
      if (ack !== onehot(order[f]) || stray)
        $display("FAIL all_pending_ack%0d: got ack=%b stray=%b, want %b stray=0",
                 f, ack, stray, onehot(order[f]));
      else n_pass++;
      if (f > 0) begin
        n_checks++;
        if (waited != GAP + 1)
          $display("FAIL all_pending_gap%0d: got %0d cycles, want %0d", f, waited, GAP + 1);
        else n_pass++;
      end
      m_ptr = (order[f] + 1) % NREQ;
    end
    req = '0;
  endtask

  task automatic test_single();
    bit ok, stray; int waited, gid; logic [7:0] dat, late; logic [3:0] ack; logic terr;
    wait_idle();
    req_data = $urandom;
    req_data[2*8 +: 8] = 8'hA5;
    req = 4'b0100;
    @(negedge clk);
    n_checks++;
    if ({frame_en, busy, grant_id, data_frame} !== {1'b1, 1'b1, 2'd2, 8'hA5})
      $display("FAIL single_launch: got fen=%b busy=%b gid=%0d data=%h, want 1 1 2 a5",
               frame_en, busy, grant_id, data_frame);
    else n_pass++;
    run_frame(12, 1'b0, ok, waited, gid, dat, late, ack, stray, terr);
    n_checks++;
    if (!ok || ack !== 4'b0100 || stray)
      $display("FAIL single_ack: got ack=%b stray=%b, want 0100 stray=0", ack, stray);
    else n_pass++;
    req = '0;
    m_ptr = 3;
  endtask

  task automatic test_hold();
    bit ok, stray; int waited, gid; logic [7:0] dat, late; logic [3:0] ack; logic terr;
    wait_idle();
    req_data[1*8 +: 8] = 8'h3C;
    req = 4'b0010;
    run_frame(40, 1'b1, ok, waited, gid, dat, late, ack, stray, terr);
    n_checks++;
    if (!ok || dat !== 8'h3C || late !== 8'h3C)
      $display("FAIL hold_data: got launch=%h late=%h, want 3c", dat, late);
    else n_pass++;
    n_checks++;
    if (gid != 1 || ack !== 4'b0010)
      $display("FAIL hold_ack: got gid=%0d ack=%b, want 1 0010", gid, ack);
    else n_pass++;
    req = '0;
    m_ptr = 2;
  endtask

  task automatic test_timeout();
    bit ok, stray; int waited, gid, cyc, exp; logic [7:0] dat, late; logic [3:0] ack; logic terr;
    wait_idle();
    req_data = 32'h44_33_22_11;
    req = 4'b0101;
    exp = rr_pick(req, m_ptr);
    for (int i = 0; i < 300 && !frame_en; i++) @(negedge clk);
    n_checks++;
    if (!frame_en || int'(grant_id) != exp)
      $display("FAIL timeout_grant: got fen=%b gid=%0d, want 1 %0d", frame_en, grant_id, exp);
    else n_pass++;
    cyc = 0; stray = 1'b0;
    while (cyc < 300 && !timeout_err) begin
      @(negedge clk);
      cyc++;
      if (req_ack != 4'b0 || frame_en) stray = 1'b1;
    end
    n_checks++;
    if (cyc != TMO || stray)
      $display("FAIL timeout_delay: got %0d cycles stray=%b, want %0d stray=0", cyc, stray, TMO);
    else n_pass++;
    m_ptr = (exp + 1) % NREQ;
    req[exp] = 1'b0;
    exp = rr_pick(req, m_ptr);
    run_frame(8, 1'b0, ok, waited, gid, dat, late, ack, stray, terr);
    n_checks++;
    if (!ok || waited != GAP + 1 || gid != exp || ack !== onehot(exp))
      $display("FAIL timeout_next: got wait=%0d gid=%0d ack=%b, want %0d %0d %b",
               waited, gid, ack, GAP + 1, exp, onehot(exp));
    else n_pass++;
    req = '0;
    m_ptr = (exp + 1) % NREQ;
  endtask

  task automatic test_race_and_stray();
    bit ok, stray; int waited, gid; logic [7:0] dat, late; logic [3:0] ack; logic terr;
    bit bad;
    wait_idle();
    req = 4'b0100;
    run_frame(TMO - 1, 1'b0, ok, waited, gid, dat, late, ack, stray, terr);
    n_checks++;
    if (!ok || ack !== 4'b0100 || terr !== 1'b0 || stray)
      $display("FAIL race_ack: got ack=%b terr=%b stray=%b, want 0100 0 0", ack, terr, stray);
    else n_pass++;
    req = '0;
    m_ptr = 3;
    wait_idle();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (req_ack != 4'b0 || busy || frame_en || timeout_err) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL stray_done: got activity after idle tx_done, want none");
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok, stray; int waited, gid; logic [7:0] dat, late; logic [3:0] ack; logic terr;
    bit bad;
    wait_idle();
    req = 4'b1000;
    for (int i = 0; i < 300 && !frame_en; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ack, frame_en, data_frame, busy, grant_id, timeout_err} !== 17'b0)
      $display("FAIL reset_mid_outputs: got ack=%b fen=%b data=%h busy=%b gid=%0d terr=%b, want all 0",
               req_ack, frame_en, data_frame, busy, grant_id, timeout_err);
    else n_pass++;
    bad = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (req_ack != 4'b0 || timeout_err) bad = 1'b1;
    end
    m_ptr = 0;
    req = 4'b1001;
    rst_n = 1'b1;
    run_frame(6, 1'b0, ok, waited, gid, dat, late, ack, stray, terr);
    n_checks++;
    if (!ok || bad || waited != 1 || gid != rr_pick(req, m_ptr) || ack !== 4'b0001)
      $display("FAIL reset_mid_regrant: got wait=%0d gid=%0d ack=%b bad=%b, want 1 0 0001 0",
               waited, gid, ack, bad);
    else n_pass++;
    req = '0;
    m_ptr = 1;
  endtask

  task automatic test_random();
    bit ok, stray; int waited, gid, exp; logic [7:0] dat, late; logic [3:0] ack; logic terr;
    logic [7:0] bytes[4];
    int errs = 0;
    wait_idle();
    for (int i = 0; i < NREQ; i++) begin
      bytes[i] = 8'($urandom);
      req_data[i*8 +: 8] = bytes[i];
    end
    req = 4'($urandom_range(1, 15));
    for (int f = 0; f < 24; f++) begin
      exp = rr_pick(req, m_ptr);
      run_frame(int'($urandom_range(1, 60)), 1'b0, ok, waited, gid, dat, late, ack, stray, terr);
      n_checks++;
      if (!ok || gid != exp || dat !== bytes[exp] || ack !== onehot(exp) || stray ||
          (f > 0 && waited != GAP + 1)) begin
        $display("FAIL random_frame%0d: got gid=%0d data=%h ack=%b wait=%0d stray=%b, want %0d %h %b %0d 0",
                 f, gid, dat, ack, waited, stray, exp, bytes[exp], onehot(exp), GAP + 1);
        errs++;
      end else n_pass++;
      if (errs > 3) break;
      m_ptr = (exp + 1) % NREQ;
      if ($urandom_range(0, 1) == 0) req[exp] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (i == exp || (!req[i] && $urandom_range(0, 2) == 0)) begin
          if (i != exp) req[i] = 1'b1;
          bytes[i] = 8'($urandom);
          req_data[i*8 +: 8] = bytes[i];
        end
      end
      if (req == 4'b0) req[$urandom_range(0, 3)] = 1'b1;
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_all_pending();
    test_single();
    test_hold();
    test_timeout();
    test_race_and_stray();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
